// File: rtl/vector_mem_sequencer.sv
// Vector/scalar memory sequencer: walks the active lanes of a vector access one
// cache transaction at a time, optionally reusing read data for repeated addresses.
module vector_mem_sequencer #(
  parameter int THREADS  = 4,
  parameter bit COALESCE = 1'b1
) (
  input  logic                    CLK,
  input  logic                    nRST,
  input  logic                    readReq,
  input  logic                    writeReq,
  input  logic                    isVector,
  input  logic [THREADS-1:0]      mask,
  input  logic [32*THREADS-1:0]   vdaddr,
  input  logic [32*THREADS-1:0]   vdstore,
  input  logic [31:0]             sdaddr,
  input  logic [31:0]             sdstore,
  output logic                    dHit,
  output logic                    busy,
  output logic [32*THREADS-1:0]   vdload,
  output logic [31:0]             sdload,
  output logic                    dmemREN,
  output logic                    dmemWEN,
  output logic [31:0]             dmemaddr,
  output logic [31:0]             dmemstore,
  input  logic [31:0]             dmemload,
  input  logic                    dcacheHit
);

  localparam int LW = (THREADS > 1) ? $clog2(THREADS) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;

  state_t                 state_r, state_s;
  logic [LW-1:0]          lane_r, lane_s;
  logic                   vec_r, wr_r;
  logic [THREADS-1:0]     mask_r;
  logic [31:0]            addr_r [THREADS];
  logic [31:0]            data_r [THREADS];
  logic [31:0]            s_addr_r, s_data_r;
  logic                   prev_valid_r;
  logic [31:0]            prev_addr_r, prev_data_r;
  logic [32*THREADS-1:0]  vdload_r;
  logic [31:0]            sdload_r;

  logic                   accept_s, step_s, coalesce_s;
  logic [LW:0]            first_s, next_s;
  logic [31:0]            cur_addr_s, cur_data_s, load_data_s;

  // Lowest set bit of m at or above start, as {found, index}.
  function automatic logic [LW:0] find_set(input logic [THREADS-1:0] m, input int start);
    logic [LW:0] res;
    res = {(LW+1){1'b0}};
    for (int i = THREADS-1; i >= 0; i--) begin
      if (i >= start && m[i]) res = {1'b1, i[LW-1:0]};
      else                    res = res;
    end
    return res;
  endfunction

  assign accept_s    = (state_r == IDLE) && (readReq || writeReq);
  assign first_s     = find_set(mask, 0);
  assign next_s      = find_set(mask_r, int'(lane_r) + 1);
  assign cur_addr_s  = vec_r ? addr_r[lane_r] : s_addr_r;
  assign cur_data_s  = vec_r ? data_r[lane_r] : s_data_r;
  // Reuse is only against the lane serviced immediately before, and never for stores.
  assign coalesce_s  = COALESCE && vec_r && !wr_r && prev_valid_r && (cur_addr_s == prev_addr_r);
  assign load_data_s = coalesce_s ? prev_data_r : dmemload;

  // Next-state and lane-advance logic.
  always_comb begin
    state_s = state_r;
    lane_s  = lane_r;
    step_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          if (!isVector) begin
            state_s = ACCESS;
            lane_s  = {LW{1'b0}};
          end else if (first_s[LW]) begin
            state_s = ACCESS;
            lane_s  = first_s[LW-1:0];
          end else begin
            state_s = DONE;
          end
        end else begin
          state_s = IDLE;
        end
      end
      ACCESS: begin
        step_s = coalesce_s || dcacheHit;
        if (step_s && vec_r && next_s[LW]) begin
          lane_s = next_s[LW-1:0];
        end else if (step_s) begin
          state_s = DONE;
        end else begin
          state_s = ACCESS;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State, request capture and load-result registers.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_r      <= IDLE;
      lane_r       <= {LW{1'b0}};
      vec_r        <= 1'b0;
      wr_r         <= 1'b0;
      mask_r       <= {THREADS{1'b0}};
      s_addr_r     <= 32'd0;
      s_data_r     <= 32'd0;
      prev_valid_r <= 1'b0;
      prev_addr_r  <= 32'd0;
      prev_data_r  <= 32'd0;
      vdload_r     <= {(32*THREADS){1'b0}};
      sdload_r     <= 32'd0;
      for (int i = 0; i < THREADS; i++) begin
        addr_r[i] <= 32'd0;
        data_r[i] <= 32'd0;
      end
    end else begin
      state_r <= state_s;
      lane_r  <= lane_s;
      if (accept_s) begin
        vec_r        <= isVector;
        wr_r         <= writeReq;
        mask_r       <= mask;
        s_addr_r     <= sdaddr;
        s_data_r     <= sdstore;
        prev_valid_r <= 1'b0;
        for (int i = 0; i < THREADS; i++) begin
          addr_r[i] <= vdaddr[32*i +: 32];
          data_r[i] <= vdstore[32*i +: 32];
        end
      end else if (state_r == ACCESS && step_s && !wr_r) begin
        prev_valid_r <= 1'b1;
        prev_addr_r  <= cur_addr_s;
        prev_data_r  <= load_data_s;
        if (vec_r) vdload_r[32*int'(lane_r) +: 32] <= load_data_s;
        else       sdload_r <= load_data_s;
      end else begin
        prev_valid_r <= prev_valid_r;
      end
    end
  end

  assign dHit      = (state_r == DONE);
  assign busy      = (state_r != IDLE);
  assign dmemREN   = (state_r == ACCESS) && !wr_r && !coalesce_s;
  assign dmemWEN   = (state_r == ACCESS) && wr_r;
  assign dmemaddr  = ((state_r == ACCESS) && !coalesce_s) ? cur_addr_s : 32'd0;
  assign dmemstore = ((state_r == ACCESS) && wr_r) ? cur_data_s : 32'd0;
  assign vdload    = vdload_r;
  assign sdload    = sdload_r;

endmodule

// File: tb/tb_vector_mem_sequencer.sv
// Directed self-checking bench for vector_mem_sequencer (THREADS=4, COALESCE=1).
module tb_vector_mem_sequencer;

  logic         CLK = 1'b0;
  logic         nRST, readReq, writeReq, isVector, dcacheHit;
  logic [3:0]   mask;
  logic [127:0] vdaddr, vdstore, vdload;
  logic [31:0]  sdaddr, sdstore, sdload, dmemaddr, dmemstore, dmemload;
  logic         dHit, busy, dmemREN, dmemWEN;
  int           checks = 0;
  int           errors = 0;
  int           ren_cnt;

  vector_mem_sequencer #(.THREADS(4), .COALESCE(1'b1)) dut (
    .CLK(CLK), .nRST(nRST), .readReq(readReq), .writeReq(writeReq),
    .isVector(isVector), .mask(mask), .vdaddr(vdaddr), .vdstore(vdstore),
    .sdaddr(sdaddr), .sdstore(sdstore), .dHit(dHit), .busy(busy),
    .vdload(vdload), .sdload(sdload), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
    .dmemaddr(dmemaddr), .dmemstore(dmemstore), .dmemload(dmemload),
    .dcacheHit(dcacheHit)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    nRST = 1'b0; readReq = 1'b0; writeReq = 1'b0; isVector = 1'b0; dcacheHit = 1'b0;
    mask = 4'd0; vdaddr = 128'd0; vdstore = 128'd0; sdaddr = 32'd0; sdstore = 32'd0;
    dmemload = 32'd0;
    tick(); tick();
    nRST = 1'b1;
    check("rst_busy", busy, 1'b0);
    check("rst_dhit", dHit, 1'b0);
    check("rst_ren_wen", {dmemREN, dmemWEN}, 2'b00);
    check("rst_addr", dmemaddr, 32'd0);
    check("rst_vdload", vdload, 128'd0);
    check("rst_sdload", sdload, 32'd0);

    // Four-lane read, one hit per cycle, dmemload = addr + 1.
    vdaddr = {32'h10C, 32'h108, 32'h104, 32'h100};
    mask = 4'b1111; isVector = 1'b1; readReq = 1'b1;
    tick();
    readReq = 1'b0;
    vdaddr = {4{32'hDEAD_0000}};
    for (int k = 0; k < 4; k++) begin
      check("v4_ren", {dmemREN, dmemWEN}, 2'b10);
      check("v4_addr", dmemaddr, 32'h100 + 32'(4*k));
      check("v4_no_dhit", dHit, 1'b0);
      writeReq  = (k == 1);
      dcacheHit = 1'b1;
      dmemload  = 32'h100 + 32'(4*k) + 32'd1;
      tick();
    end
    writeReq = 1'b0; dcacheHit = 1'b0;
    check("v4_dhit", {dHit, busy}, 2'b11);
    check("v4_idle_bus", {dmemREN, dmemWEN}, 2'b00);
    check("v4_vdload", vdload, {32'h10D, 32'h109, 32'h105, 32'h101});
    tick();
    check("v4_after", {dHit, busy}, 2'b00);

    // Masked write: only lanes 0 and 2.
    vdaddr  = {32'h30C, 32'h308, 32'h304, 32'h300};
    vdstore = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    mask = 4'b0101; writeReq = 1'b1;
    tick();
    writeReq = 1'b0; dcacheHit = 1'b1;
    check("vw_l0", {dmemREN, dmemWEN, dmemaddr, dmemstore}, {2'b01, 32'h300, 32'hA0});
    tick();
    check("vw_l2", {dmemREN, dmemWEN, dmemaddr, dmemstore}, {2'b01, 32'h308, 32'hA2});
    check("vw_no_dhit", dHit, 1'b0);
    tick();
    dcacheHit = 1'b0;
    check("vw_dhit", dHit, 1'b1);
    check("vw_retain", vdload, {32'h10D, 32'h109, 32'h105, 32'h101});
    check("vw_store_idle", dmemstore, 32'd0);
    tick();

    // Coalesced read: all lanes at 0x200, only the first reaches the cache.
    vdaddr = {4{32'h200}};
    mask = 4'b1111; readReq = 1'b1;
    tick();
    readReq = 1'b0; dcacheHit = 1'b1; dmemload = 32'h55;
    ren_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      if (dmemREN) ren_cnt++;
      if (k > 0) check("co_quiet", {dmemREN, dmemWEN}, 2'b00);
      check("co_no_dhit", dHit, 1'b0);
      tick();
      dmemload = 32'h99;
    end
    dcacheHit = 1'b0;
    check("co_ren_cnt", 32'(ren_cnt), 32'd1);
    check("co_dhit", dHit, 1'b1);
    check("co_vdload", vdload, {4{32'h55}});
    tick();

    // Empty mask: straight to DONE.
    mask = 4'b0000; readReq = 1'b1;
    tick();
    readReq = 1'b0;
    check("m0_dhit", {dHit, dmemREN, dmemWEN}, 3'b100);
    tick();
    check("m0_idle", busy, 1'b0);

    // Scalar read with three wait cycles.
    isVector = 1'b0; sdaddr = 32'h40; mask = 4'b1111; readReq = 1'b1;
    tick();
    readReq = 1'b0; ren_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      if (dmemREN && dmemaddr == 32'h40) ren_cnt++;
      dcacheHit = (k == 3);
      dmemload  = (k == 3) ? 32'hDEAD_BEEF : 32'h1111_1111;
      tick();
    end
    dcacheHit = 1'b0;
    check("sc_ren_cnt", 32'(ren_cnt), 32'd4);
    check("sc_dhit", dHit, 1'b1);
    check("sc_sdload", sdload, 32'hDEAD_BEEF);
    tick();

    // Reset during lane 2 of a four-lane read.
    isVector = 1'b1; mask = 4'b1111;
    vdaddr = {32'h10C, 32'h108, 32'h104, 32'h100};
    readReq = 1'b1;
    tick();
    readReq = 1'b0; dcacheHit = 1'b1; dmemload = 32'h77;
    tick(); tick();
    check("rm_lane2", dmemaddr, 32'h108);
    nRST = 1'b0;
    tick();
    nRST = 1'b1; dcacheHit = 1'b0;
    check("rm_outs", {dHit, busy, dmemREN, dmemWEN, dmemaddr, dmemstore}, 68'd0);
    check("rm_loads", {vdload, sdload}, 160'd0);
    ren_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      if (dHit || busy) ren_cnt++;
      tick();
    end
    check("rm_no_resume", 32'(ren_cnt), 32'd0);

    // Simultaneous read and write requests act as a write.
    isVector = 1'b0; sdaddr = 32'h80; sdstore = 32'h1234;
    readReq = 1'b1; writeReq = 1'b1;
    tick();
    readReq = 1'b0; writeReq = 1'b0; dcacheHit = 1'b1;
    check("rw_write", {dmemREN, dmemWEN, dmemaddr, dmemstore}, {2'b01, 32'h80, 32'h1234});
    tick();
    dcacheHit = 1'b0;
    check("rw_dhit", dHit, 1'b1);
    check("rw_sdload_kept", sdload, 32'd0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vector_mem_sequencer.md
VECTOR_MEM_SEQUENCER -- requirements
Module: vector_mem_sequencer

Interface
REQ-001 Parameter THREADS, default 4, SHALL set lane count (legal 1..16).
REQ-002 Parameter COALESCE, default 1, SHALL enable same-address read reuse when 1.
REQ-003 Ports SHALL be, one per line (name direction width meaning):
  CLK  in  1  single clock; all state on rising edge
  nRST  in  1  synchronous active-low reset
  readReq  in  1  load request
  writeReq  in  1  store request
  isVector  in  1  1 = vector access over lanes; 0 = scalar access
  mask  in  THREADS  lane-active bits, vector mode only
  vdaddr  in  32*THREADS  lane addresses, lane i at bits [32i+31:32i]
  vdstore  in  32*THREADS  lane store data, same packing
  sdaddr  in  32  scalar address
  sdstore  in  32  scalar store data
  dHit  out  1  one-cycle completion pulse
  busy  out  1  request in progress
  vdload  out  32*THREADS  lane load results
  sdload  out  32  scalar load result
  dmemREN  out  1  cache read enable
  dmemWEN  out  1  cache write enable
  dmemaddr  out  32  cache address
  dmemstore  out  32  cache store data
  dmemload  in  32  cache read data
  dcacheHit  in  1  cache access complete this cycle
REQ-004 Clock SHALL be CLK; reset SHALL be nRST, synchronous, active-low.

Function
REQ-005 FSM states SHALL be IDLE, ACCESS, DONE.
REQ-006 In IDLE with readReq or writeReq high, block SHALL latch isVector, mask, addresses, store data and op, and leave IDLE next edge.
REQ-007 readReq and writeReq both high SHALL be accepted as a write.
REQ-008 Requests SHALL be ignored outside IDLE; latched copies are used for the whole operation.
REQ-009 Vector accept with mask nonzero: go ACCESS at lowest set lane; mask zero: go DONE directly, no cache access.
REQ-010 Scalar accept SHALL go ACCESS for one access using sdaddr/sdstore; mask ignored.
REQ-011 In ACCESS, dmemREN (read) or dmemWEN (write) SHALL be high, dmemaddr/dmemstore driven from current lane, held stable until dcacheHit.
REQ-012 On dcacheHit in a read, dmemload SHALL be registered into current lane of vdload (vector) or sdload (scalar).
REQ-013 After each hit, lane index SHALL advance to next higher set mask bit; none left -> DONE.
REQ-014 Inactive lanes SHALL be skipped in zero cycles; their vdload entries SHALL retain prior values.
REQ-015 COALESCE=1, vector read: a lane whose address equals the previously serviced lane's address SHALL copy that lane's data, spend one ACCESS cycle with dmemREN=dmemWEN=0, and issue no cache access.
REQ-016 Writes SHALL never coalesce.
REQ-017 DONE SHALL last one cycle with dHit=1, then return to IDLE; a new request is accepted no earlier than the IDLE cycle after.
REQ-018 busy SHALL be 1 in ACCESS and DONE, 0 in IDLE.
REQ-019 dmemREN and dmemWEN SHALL never both be high; both SHALL be 0 outside ACCESS.
REQ-020 Latency with no coalescing and single-cycle hits SHALL be 1 + active-lane-count cycles accept-to-dHit (scalar: 2).
REQ-021 dcacheHit outside ACCESS SHALL be ignored.

Reset
REQ-022 nRST low at an edge SHALL force IDLE, lane index 0, and all outputs (dHit, busy, dmemREN, dmemWEN, dmemaddr, dmemstore, vdload, sdload) to 0, including mid-operation.
REQ-023 Operation aborted by reset SHALL not resume; no dHit is produced for it.

Verification
REQ-024 Vector read, THREADS=4, mask=4'b1111, addrs 0x100/104/108/10C, hit each cycle, dmemload=addr+1 -> four REN cycles in lane order, vdload={0x10D,0x109,0x105,0x101}, dHit at cycle 5 after accept.
REQ-025 Vector write, mask=4'b0101, data A0/A1/A2/A3 -> WEN only for lanes 0,2 with addr/data lane0 then lane2, dHit after 3 cycles.
REQ-026 Vector read mask=4'b1111, all addrs 0x200, COALESCE=1, dmemload=0x55 -> one REN cycle, three idle ACCESS cycles, all lanes 0x55.
REQ-027 mask=0 vector read -> no REN/WEN, dHit the cycle after accept; scalar read sdaddr 0x40, hit after 3 wait cycles -> REN held 4 cycles, sdload=dmemload.
REQ-028 nRST low during lane 2 of 4-lane read -> next cycle IDLE, outputs 0, no dHit; readReq+writeReq together -> write performed.
